// File: rtl/dispense_pkg.sv
// rtl/dispense_pkg.sv - shared types and codes for the candy dispense sequencer
//
// Purpose: sequencer state encoding, Pi amount codes and DC motor drive codes.
// Ports: none (package).

package dispense_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    STEP  = 3'd2,
    TAIL  = 3'd3,
    CLOSE = 3'd4
  } state_t;

  localparam logic [1:0] AMT_SMALL   = 2'b00;
  localparam logic [1:0] AMT_MED     = 2'b01;
  localparam logic [1:0] AMT_LARGE   = 2'b10;
  localparam logic [1:0] AMT_INVALID = 2'b11;

  localparam logic [1:0] DC_STOP = 2'b00;
  localparam logic [1:0] DC_FWD  = 2'b01;
  localparam logic [1:0] DC_REV  = 2'b10;

endpackage

// File: rtl/stepper_pulse_gen.sv
// rtl/stepper_pulse_gen.sv - stepper step pulse train with step counting
//
// Purpose: while enable is high, emits a square wave (STEP_DIV cycles high,
//   STEP_DIV cycles low) starting with a high phase on the first enabled
//   cycle, and counts completed steps at each high-to-low transition.
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   enable        - run request; low clears everything synchronously
//   target        - number of steps to produce
//   stepper_step  - registered step output
//   step_done     - high during the last cycle of the final low phase

module stepper_pulse_gen
  import dispense_pkg::*;
#(
  parameter int STEP_DIV = 6000,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  output logic             stepper_step,
  output logic             step_done
);

  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_step;
  logic             w_phase_end;

  assign w_phase_end = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_step   <= 1'b0;
    end else if (!enable) begin
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_step   <= 1'b0;
    end else if (!r_active) begin
      // First enabled edge starts the first high phase immediately.
      r_active <= 1'b1;
      r_step   <= 1'b1;
      r_div    <= '0;
    end else if (w_phase_end) begin
      r_div  <= '0;
      r_step <= ~r_step;
      if (r_step && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // The final low phase runs to completion so every step is a full period.
  assign step_done    = r_active && !r_step && w_phase_end && (r_cnt == target);
  assign stepper_step = r_step;

endmodule

// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - interlocked candy dispense sequence controller
//
// Purpose: accepts a synchronized candy request from the Pi, opens the servo
//   flap, runs the stepper for the requested amount with the DC agitator on,
//   keeps the agitator running for a tail period, then closes the flap.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   candy_flag, amount   - asynchronous request and amount code from the Pi
//   abort                - synchronous level abort
//   dir_sel              - stepper direction captured at acceptance
//   sig_received         - pulse when a request is accepted (valid or not)
//   stepper_step/_dir    - stepper driver pins
//   dcmotor              - DC motor drive pair
//   servo_open           - flap command level
//   busy, done, err      - status: in sequence, normal completion, bad amount

module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int         CLK_FREQ     = 12000000,
  parameter int         STEP_DIV     = CLK_FREQ / 2000,
  parameter int         SMALL_STEPS  = 200,
  parameter int         MED_STEPS    = 400,
  parameter int         LARGE_STEPS  = 800,
  parameter int         SERVO_SETTLE = (CLK_FREQ / 10) * 3,
  parameter int         DC_TAIL      = CLK_FREQ / 10,
  parameter logic [1:0] DC_DRIVE     = 2'b01
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       candy_flag,
  input  logic [1:0] amount,
  input  logic       abort,
  input  logic       dir_sel,
  output logic       sig_received,
  output logic       stepper_step,
  output logic       stepper_dir,
  output logic [1:0] dcmotor,
  output logic       servo_open,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TMR_MAX_A = (STEP_DIV > SERVO_SETTLE) ? STEP_DIV : SERVO_SETTLE;
  localparam int TMR_MAX   = (TMR_MAX_A > DC_TAIL) ? TMR_MAX_A : DC_TAIL;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int CNT_W     = $clog2(LARGE_STEPS + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SERVO_SETTLE - 1);
  localparam logic [TMR_W-1:0] TAIL_LAST   = TMR_W'(DC_TAIL - 1);
  localparam logic [TMR_W-1:0] TMR_SAT     = '1;

  localparam logic [CNT_W-1:0] SMALL_T = CNT_W'(SMALL_STEPS);
  localparam logic [CNT_W-1:0] MED_T   = CNT_W'(MED_STEPS);
  localparam logic [CNT_W-1:0] LARGE_T = CNT_W'(LARGE_STEPS);

  // Any illegal drive setting collapses to forward so 2'b11 can never appear.
  localparam logic [1:0] DC_CODE = (DC_DRIVE == DC_REV) ? DC_REV : DC_FWD;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] w_target_sel;

  logic [2:0]       r_flag_sync;
  logic [1:0]       r_amt_s1;
  logic [1:0]       r_amt_s2;
  logic             r_req;
  logic [1:0]       r_req_amt;

  logic             r_dir;
  logic             r_aborted;
  logic             r_sig;
  logic             r_err;
  logic             r_busy;
  logic             r_servo;
  logic [1:0]       r_dc;
  logic             r_done;

  logic             w_accept;
  logic             w_bad_req;
  logic             w_finish;
  logic             w_abort_go;
  logic             w_step_en;
  logic             w_step;
  logic             w_step_done;

  // Flag synchronizer plus edge-detect flop. Resetting them high means a
  // flag already held high at reset release never looks like a new edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flag_sync <= 3'b111;
      r_amt_s1    <= '0;
      r_amt_s2    <= '0;
      r_req       <= 1'b0;
      r_req_amt   <= '0;
    end else begin
      r_flag_sync <= {r_flag_sync[1:0], candy_flag};
      r_amt_s1    <= amount;
      r_amt_s2    <= r_amt_s1;
      r_req       <= r_flag_sync[1] & ~r_flag_sync[2];
      r_req_amt   <= r_amt_s2;
    end
  end

  always_comb begin
    w_target_sel = SMALL_T;
    case (r_req_amt)
      AMT_MED:   w_target_sel = MED_T;
      AMT_LARGE: w_target_sel = LARGE_T;
      default:   w_target_sel = SMALL_T;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort is checked before timer/step completion so it always wins.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad_req   = 1'b0;
    w_finish    = 1'b0;
    w_abort_go  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_req) begin
          if (r_req_amt == AMT_INVALID) begin
            w_bad_req = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = OPEN;
          end
        end
      end
      OPEN: begin
        if (abort) begin
          w_abort_go  = 1'b1;
          w_state_nxt = CLOSE;
        end else if (r_timer == SETTLE_LAST) begin
          w_state_nxt = STEP;
        end
      end
      STEP: begin
        if (abort) begin
          w_abort_go  = 1'b1;
          w_state_nxt = CLOSE;
        end else if (w_step_done) begin
          w_state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (abort) begin
          w_abort_go  = 1'b1;
          w_state_nxt = CLOSE;
        end else if (r_timer == TAIL_LAST) begin
          w_state_nxt = CLOSE;
        end
      end
      CLOSE: begin
        if (r_timer == SETTLE_LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared wait timer: restarts on every state change, saturates otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timer <= '0;
    end else if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
      r_timer <= '0;
    end else if (r_timer != TMR_SAT) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change together
  // with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_target  <= '0;
      r_dir     <= 1'b0;
      r_aborted <= 1'b0;
      r_sig     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_servo   <= 1'b0;
      r_dc      <= DC_STOP;
      r_done    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_target  <= w_target_sel;
        r_dir     <= dir_sel;
        r_aborted <= 1'b0;
      end else if (w_abort_go) begin
        r_aborted <= 1'b1;
      end
      r_sig   <= w_accept | w_bad_req;
      r_err   <= w_bad_req;
      r_busy  <= (w_state_nxt != IDLE);
      r_servo <= (w_state_nxt == OPEN) || (w_state_nxt == STEP) || (w_state_nxt == TAIL);
      r_dc    <= ((w_state_nxt == STEP) || (w_state_nxt == TAIL)) ? DC_CODE : DC_STOP;
      r_done  <= w_finish & ~r_aborted;
    end
  end

  // Driven from the next state so the first high phase lines up with STEP
  // entry and the output drops on the same edge STEP is left.
  assign w_step_en = (w_state_nxt == STEP);

  stepper_pulse_gen #(
    .STEP_DIV (STEP_DIV),
    .CNT_W    (CNT_W)
  ) u_pulse_gen (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (w_step_en),
    .target       (r_target),
    .stepper_step (w_step),
    .step_done    (w_step_done)
  );

  assign sig_received = r_sig;
  assign stepper_step = w_step;
  assign stepper_dir  = r_dir;
  assign dcmotor      = r_dc;
  assign servo_open   = r_servo;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - directed self-checking bench for dispense_sequencer

module tb_dispense_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       candy_flag = 1'b0;
  logic [1:0] amount = 2'b00;
  logic       abort = 1'b0;
  logic       dir_sel = 1'b0;
  logic       sig_received;
  logic       stepper_step;
  logic       stepper_dir;
  logic [1:0] dcmotor;
  logic       servo_open;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  int   mon_sig  = 0;
  int   mon_done = 0;
  int   mon_err  = 0;
  int   mon_rise = 0;
  logic prev_step = 1'b0;

  dispense_sequencer #(
    .STEP_DIV     (2),
    .SMALL_STEPS  (3),
    .MED_STEPS    (5),
    .LARGE_STEPS  (8),
    .SERVO_SETTLE (4),
    .DC_TAIL      (6),
    .DC_DRIVE     (2'b01)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .candy_flag   (candy_flag),
    .amount       (amount),
    .abort        (abort),
    .dir_sel      (dir_sel),
    .sig_received (sig_received),
    .stepper_step (stepper_step),
    .stepper_dir  (stepper_dir),
    .dcmotor      (dcmotor),
    .servo_open   (servo_open),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (sig_received) mon_sig <= mon_sig + 1;
      if (done) mon_done <= mon_done + 1;
      if (err) mon_err <= mon_err + 1;
      if (stepper_step && !prev_step) mon_rise <= mon_rise + 1;
    end
    prev_step <= stepper_step;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {busy, servo_open, dcmotor, stepper_step, done, sig_received, err};
  endfunction

  // Hand timeline relative to the edge that first samples candy_flag high:
  // OPEN 3..6, STEP 7..6+4n, TAIL next 6, CLOSE next 4, done at 17+4n.
  function automatic logic [7:0] exp_vec(input int k, input int n);
    logic       b, s, st, d, sg;
    logic [1:0] dc;
    b  = (k >= 3) && (k <= 16 + 4 * n);
    s  = (k >= 3) && (k <= 12 + 4 * n);
    dc = ((k >= 7) && (k <= 12 + 4 * n)) ? 2'b01 : 2'b00;
    st = (k >= 7) && (k <= 6 + 4 * n) && (((k - 7) % 4) < 2);
    d  = (k == 17 + 4 * n);
    sg = (k == 3);
    return {b, s, dc, st, d, sg, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input string name, input logic [1:0] amt, input int n,
                         input logic dir, input bit pulse, input int flag_off_k,
                         input int flag_on_k, input int dir_flip_k);
    int s0, d0, r0;
    s0 = mon_sig;
    d0 = mon_done;
    r0 = mon_rise;
    amount     = amt;
    dir_sel    = dir;
    candy_flag = 1'b1;
    for (int k = 0; k <= 17 + 4 * n; k++) begin
      tick();
      if (k == 0 && pulse) candy_flag = 1'b0;
      if (k == flag_off_k) candy_flag = 1'b0;
      if (k == flag_on_k) candy_flag = 1'b1;
      if (k == dir_flip_k) dir_sel = ~dir_sel;
      if (k >= 1) chk($sformatf("%s_k%0d", name, k), {24'd0, obs()}, {24'd0, exp_vec(k, n)});
      if (k == 3 || k == 6 + 4 * n) chk($sformatf("%s_dir_k%0d", name, k), {31'd0, stepper_dir}, {31'd0, dir});
    end
    candy_flag = 1'b0;
    repeat (3) tick();
    chk({name, "_steps"}, mon_rise - r0, n);
    chk({name, "_sig_count"}, mon_sig - s0, 1);
    chk({name, "_done_count"}, mon_done - d0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, r0, e0;
    logic [7:0] ev;

    repeat (3) tick();
    chk("reset_outs", {24'd0, obs()}, 32'd0);
    chk("reset_dir", {31'd0, stepper_dir}, 32'd0);
    rstn = 1'b1;
    repeat (4) tick();
    chk("idle_outs", {24'd0, obs()}, 32'd0);

    run_seq("small", 2'b00, 3, 1'b1, 1'b0, -1, -1, 10);
    run_seq("large", 2'b10, 8, 1'b0, 1'b0, 10, 14, -1);

    // Invalid amount: sig_received and err together, nothing else moves.
    e0 = mon_err;
    amount     = 2'b11;
    candy_flag = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k >= 1) chk($sformatf("invalid_k%0d", k), {24'd0, obs()}, (k == 3) ? 32'h03 : 32'h00);
    end
    candy_flag = 1'b0;
    repeat (3) tick();
    chk("invalid_err_count", mon_err - e0, 1);

    // Abort during the second step's high phase of a MED sequence.
    d0 = mon_done;
    r0 = mon_rise;
    amount     = 2'b01;
    dir_sel    = 1'b0;
    candy_flag = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 11) abort = 1'b1;
      if (k == 12) abort = 1'b0;
      ev = (k <= 11) ? exp_vec(k, 5) : {(k <= 15), 7'b0};
      if (k >= 1) chk($sformatf("abort_k%0d", k), {24'd0, obs()}, {24'd0, ev});
    end
    candy_flag = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", mon_done - d0, 0);
    chk("abort_steps", mon_rise - r0, 2);

    run_seq("after_abort", 2'b01, 5, 1'b1, 1'b0, -1, -1, -1);

    // Reset mid-STEP with the flag held high throughout.
    amount     = 2'b01;
    dir_sel    = 1'b1;
    candy_flag = 1'b1;
    for (int k = 0; k <= 9; k++) tick();
    chk("pre_reset_k9", {24'd0, obs()}, {24'd0, exp_vec(9, 5)});
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_outs", {24'd0, obs()}, 32'd0);
    chk("async_reset_dir", {31'd0, stepper_dir}, 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    s0 = mon_sig;
    repeat (10) tick();
    chk("held_flag_no_sig", mon_sig - s0, 0);
    chk("held_flag_not_busy", {31'd0, busy}, 32'd0);
    candy_flag = 1'b0;
    repeat (3) tick();

    run_seq("after_reset", 2'b00, 3, 1'b0, 1'b0, -1, -1, -1);
    run_seq("pulse", 2'b01, 5, 1'b1, 1'b1, -1, -1, 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
